// File: rtl/fast_pkg.sv
// rtl/fast_pkg.sv - shared pixel/circle/mask types and threshold compare helpers for FAST corner detection
package fast_pkg;

    localparam int PIX_W    = 8;
    localparam int N_CIRCLE = 16;

    typedef logic [PIX_W-1:0]              pixel_t;
    typedef pixel_t [N_CIRCLE-1:0]         circle_t;
    typedef logic [N_CIRCLE-1:0]           mask_t;

    // Compared at 9 bits so ctr + t never wraps.
    function automatic logic is_bright(input pixel_t p, input pixel_t c, input pixel_t t);
        return {1'b0, p} > ({1'b0, c} + {1'b0, t});
    endfunction

    function automatic logic is_dark(input pixel_t p, input pixel_t c, input pixel_t t);
        return (c >= t) && (p < (c - t));
    endfunction

endpackage

// File: rtl/fast_arc_detect.sv
// rtl/fast_arc_detect.sv - combinational search for a contiguous run of ARC_LEN set bits on the 16-point ring
module fast_arc_detect
    import fast_pkg::*;
#(
    parameter int ARC_LEN = 9
) (
    input  mask_t mask,
    output logic  hit
);

    logic [2*N_CIRCLE-1:0] ring;
    logic [N_CIRCLE-1:0]   run;

    // Doubling the mask turns every wrapped arc into a plain slice.
    assign ring = {mask, mask};

    for (genvar k = 0; k < N_CIRCLE; k++) begin : g_arc
        assign run[k] = &ring[k+ARC_LEN-1:k];
    end

    assign hit = |run;

endmodule

// File: rtl/fast_corner_detect.sv
// rtl/fast_corner_detect.sv - 3-stage FAST corner pipeline with raster position tracking and per-frame corner count
module fast_corner_detect
    import fast_pkg::*;
#(
    parameter int WIDTH          = 320,
    parameter int HEIGHT         = 240,
    parameter int ARC_LEN        = 9,
    parameter int THRESH_DEFAULT = 20
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  circle_t                   i_circle,
    input  pixel_t                    i_ctr,
    input  logic                      i_v,
    input  pixel_t                    i_thresh,
    output logic                      o_v,
    output logic                      o_corner,
    output logic [$clog2(WIDTH)-1:0]  o_x,
    output logic [$clog2(HEIGHT)-1:0] o_y,
    output logic [15:0]               o_count,
    output logic                      o_count_v
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [XW-1:0] X_MIN  = XW'(3);
    localparam logic [XW-1:0] X_MAX  = XW'(WIDTH - 4);
    localparam logic [YW-1:0] Y_MIN  = YW'(3);
    localparam logic [YW-1:0] Y_MAX  = YW'(HEIGHT - 4);

    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    pixel_t        t_reg;
    pixel_t        t_use;
    logic          first_pix;
    mask_t         bright_m;
    mask_t         dark_m;

    logic          s1_v;
    mask_t         s1_bright;
    mask_t         s1_dark;
    logic [XW-1:0] s1_x;
    logic [YW-1:0] s1_y;

    logic          hit_bright;
    logic          hit_dark;
    logic          border;

    logic          s2_v;
    logic          s2_corner;
    logic [XW-1:0] s2_x;
    logic [YW-1:0] s2_y;

    logic [15:0]   frame_cnt;
    logic [15:0]   cnt_next;
    logic          s2_last;

    // The frame's first pixel uses the freshly requested threshold directly.
    assign first_pix = (x_cnt == '0) && (y_cnt == '0);
    assign t_use     = first_pix ? i_thresh : t_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
            t_reg <= PIX_W'(THRESH_DEFAULT);
        end else if (i_v) begin
            if (first_pix) begin
                t_reg <= i_thresh;
            end
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < N_CIRCLE; k++) begin : g_mask
        assign bright_m[k] = is_bright(i_circle[k], i_ctr, t_use);
        assign dark_m[k]   = is_dark(i_circle[k], i_ctr, t_use);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_v      <= 1'b0;
            s1_bright <= '0;
            s1_dark   <= '0;
            s1_x      <= '0;
            s1_y      <= '0;
        end else begin
            s1_v      <= i_v;
            s1_bright <= bright_m;
            s1_dark   <= dark_m;
            s1_x      <= x_cnt;
            s1_y      <= y_cnt;
        end
    end

    fast_arc_detect #(.ARC_LEN(ARC_LEN)) u_arc_bright (
        .mask (s1_bright),
        .hit  (hit_bright)
    );

    fast_arc_detect #(.ARC_LEN(ARC_LEN)) u_arc_dark (
        .mask (s1_dark),
        .hit  (hit_dark)
    );

    // The radius-3 circle is not fully inside the frame near the edges.
    assign border = (s1_x < X_MIN) || (s1_x > X_MAX) || (s1_y < Y_MIN) || (s1_y > Y_MAX);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_v      <= 1'b0;
            s2_corner <= 1'b0;
            s2_x      <= '0;
            s2_y      <= '0;
        end else begin
            s2_v      <= s1_v;
            s2_corner <= s1_v && (hit_bright || hit_dark) && !border;
            s2_x      <= s1_x;
            s2_y      <= s1_y;
        end
    end

    assign s2_last  = (s2_x == X_LAST) && (s2_y == Y_LAST);
    assign cnt_next = (s2_corner && (frame_cnt != 16'hFFFF)) ? frame_cnt + 16'd1 : frame_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_v       <= 1'b0;
            o_corner  <= 1'b0;
            o_x       <= '0;
            o_y       <= '0;
            o_count   <= '0;
            o_count_v <= 1'b0;
            frame_cnt <= '0;
        end else begin
            o_v       <= s2_v;
            o_corner  <= s2_v && s2_corner;
            o_x       <= s2_x;
            o_y       <= s2_y;
            o_count_v <= 1'b0;
            if (s2_v) begin
                if (s2_last) begin
                    o_count   <= cnt_next;
                    o_count_v <= 1'b1;
                    frame_cnt <= '0;
                end else begin
                    frame_cnt <= cnt_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_fast_corner_detect.sv
// tb/tb_fast_corner_detect.sv - directed self-checking bench for fast_corner_detect on a 16x8 frame
module tb_fast_corner_detect;

    localparam int W = 16;
    localparam int H = 8;
    localparam int NPIX = W * H;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic [15:0][7:0] i_circle = '0;
    logic [7:0]       i_ctr = '0;
    logic             i_v = 1'b0;
    logic [7:0]       i_thresh = 8'd20;
    logic             o_v;
    logic             o_corner;
    logic [3:0]       o_x;
    logic [2:0]       o_y;
    logic [15:0]      o_count;
    logic             o_count_v;

    fast_corner_detect #(
        .WIDTH(W), .HEIGHT(H), .ARC_LEN(9), .THRESH_DEFAULT(20)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_circle(i_circle), .i_ctr(i_ctr),
        .i_v(i_v), .i_thresh(i_thresh), .o_v(o_v), .o_corner(o_corner),
        .o_x(o_x), .o_y(o_y), .o_count(o_count), .o_count_v(o_count_v)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    int   code [NPIX];
    logic exp_c [NPIX];
    int   in_cyc [NPIX];
    int   res_seen [NPIX];
    logic res_corner [NPIX];
    int   res_cyc [NPIX];
    int   nvalid = 0;
    int   npulse = 0;
    logic [15:0] pulse_count = '0;
    logic [3:0]  pulse_x = '0;
    logic [2:0]  pulse_y = '0;
    logic [3:0]  first_x = '1;
    logic [2:0]  first_y = '1;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_v) begin
            res_seen[int'(o_y) * W + int'(o_x)]   <= res_seen[int'(o_y) * W + int'(o_x)] + 1;
            res_corner[int'(o_y) * W + int'(o_x)] <= o_corner;
            res_cyc[int'(o_y) * W + int'(o_x)]    <= cyc;
            nvalid <= nvalid + 1;
            if (nvalid == 0) begin
                first_x <= o_x;
                first_y <= o_y;
            end
        end
        if (o_count_v) begin
            npulse      <= npulse + 1;
            pulse_count <= o_count;
            pulse_x     <= o_x;
            pulse_y     <= o_y;
        end
    end

    task automatic clear_results();
        for (int i = 0; i < NPIX; i++) begin
            res_seen[i] = 0;
            res_corner[i] = 1'b0;
            res_cyc[i] = 0;
        end
        nvalid = 0;
        npulse = 0;
        first_x = '1;
        first_y = '1;
    endtask

    task automatic clear_table();
        for (int i = 0; i < NPIX; i++) begin
            code[i] = 0;
            exp_c[i] = 1'b0;
        end
    endtask

    task automatic place(input int x, input int y, input int c, input logic e);
        code[y * W + x] = c;
        exp_c[y * W + x] = e;
    endtask

    // Pattern codes: 0 flat, 1 bright arc 9 @121, 2 arc 9 @120, 3 arc 8 @121,
    // 4 dark wrapped arc @70, 5 ctr below threshold, 6 bright arc 9 @131
    task automatic set_pix(input int c);
        i_ctr = 8'd100;
        for (int k = 0; k < 16; k++) i_circle[k] = 8'd100;
        case (c)
            1: for (int k = 0; k <= 8; k++) i_circle[k] = 8'd121;
            2: for (int k = 0; k <= 8; k++) i_circle[k] = 8'd120;
            3: for (int k = 0; k <= 7; k++) i_circle[k] = 8'd121;
            4: for (int k = 12; k <= 20; k++) i_circle[k % 16] = 8'd70;
            5: begin
                i_ctr = 8'd10;
                for (int k = 0; k < 16; k++) i_circle[k] = 8'd0;
            end
            6: for (int k = 0; k <= 8; k++) i_circle[k] = 8'd131;
            default: ;
        endcase
    endtask

    task automatic drive_frame(input int n_pix, input logic [7:0] th0, input logic [7:0] th_rest,
                               input int bubble);
        for (int i = 0; i < n_pix; i++) begin
            set_pix(code[i]);
            i_thresh = (i == 0) ? th0 : th_rest;
            i_v = 1'b1;
            in_cyc[i] = cyc;
            @(posedge i_clk);
            #1;
            if (bubble > 0 && (i % bubble) == bubble - 1) begin
                i_v = 1'b0;
                set_pix(1);
                @(posedge i_clk);
                #1;
            end
        end
        i_v = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [15:0] want_count);
        for (int i = 0; i < NPIX; i++) begin
            n_checks++;
            if (res_seen[i] !== 1) begin
                n_fail++;
                $display("FAIL %s seen(%0d,%0d) got %0d want 1", name, i % W, i / W, res_seen[i]);
            end
            n_checks++;
            if (res_corner[i] !== exp_c[i]) begin
                n_fail++;
                $display("FAIL %s corner(%0d,%0d) got %0b want %0b", name, i % W, i / W,
                         res_corner[i], exp_c[i]);
            end
            n_checks++;
            if (res_cyc[i] - in_cyc[i] !== 3) begin
                n_fail++;
                $display("FAIL %s latency(%0d,%0d) got %0d want 3", name, i % W, i / W,
                         res_cyc[i] - in_cyc[i]);
            end
        end
        n_checks++;
        if (npulse !== 1) begin
            n_fail++;
            $display("FAIL %s pulses got %0d want 1", name, npulse);
        end
        n_checks++;
        if (pulse_count !== want_count) begin
            n_fail++;
            $display("FAIL %s count got %0d want %0d", name, pulse_count, want_count);
        end
        n_checks++;
        if (pulse_x !== 4'd15 || pulse_y !== 3'd7) begin
            n_fail++;
            $display("FAIL %s pulse_pos got (%0d,%0d) want (15,7)", name, pulse_x, pulse_y);
        end
        n_checks++;
        if (o_count !== want_count || o_count_v !== 1'b0) begin
            n_fail++;
            $display("FAIL %s count_hold got %0d/%0b want %0d/0", name, o_count, o_count_v, want_count);
        end
    endtask

    task automatic fill_frame1();
        clear_table();
        place(5, 4, 0, 1'b0);
        place(3, 3, 1, 1'b1);
        place(5, 3, 2, 1'b0);
        place(7, 3, 3, 1'b0);
        place(9, 3, 4, 1'b1);
        place(11, 3, 5, 1'b0);
        place(12, 3, 1, 1'b1);
        place(2, 4, 1, 1'b0);
        place(13, 4, 1, 1'b0);
        place(6, 2, 1, 1'b0);
        place(6, 5, 1, 1'b0);
        place(8, 4, 4, 1'b1);
        place(10, 4, 1, 1'b1);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_v = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        n_checks++;
        if ({o_v, o_corner, o_count_v} !== 3'b000 || o_x !== 4'd0 || o_y !== 3'd0 || o_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%0b c=%0b cv=%0b x=%0d y=%0d cnt=%0d want all 0",
                     o_v, o_corner, o_count_v, o_x, o_y, o_count);
        end
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_frame_thresh20();
        fill_frame1();
        clear_results();
        drive_frame(NPIX, 8'd20, 8'd30, 0);
        repeat (6) @(posedge i_clk);
        #1;
        check_frame("frame_t20", 16'd5);
    endtask

    task automatic test_frame_thresh30_bubbles();
        clear_table();
        place(4, 3, 1, 1'b0);
        place(6, 3, 6, 1'b1);
        place(8, 3, 4, 1'b0);
        place(10, 4, 6, 1'b1);
        clear_results();
        drive_frame(NPIX, 8'd30, 8'd20, 5);
        repeat (6) @(posedge i_clk);
        #1;
        check_frame("frame_t30", 16'd2);
    endtask

    task automatic test_reset_midframe();
        fill_frame1();
        clear_results();
        drive_frame(40, 8'd20, 8'd20, 0);
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        clear_results();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        n_checks++;
        if (nvalid !== 0) begin
            n_fail++;
            $display("FAIL rst_inflight got %0d results want 0", nvalid);
        end
        n_checks++;
        if (o_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_count got %0d want 0", o_count);
        end
        drive_frame(NPIX, 8'd20, 8'd20, 0);
        n_checks++;
        if (o_count !== 16'd0 || npulse !== 0) begin
            n_fail++;
            $display("FAIL rst_count_pre_end got %0d/%0d pulses want 0/0", o_count, npulse);
        end
        repeat (6) @(posedge i_clk);
        #1;
        n_checks++;
        if (first_x !== 4'd0 || first_y !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_first_pos got (%0d,%0d) want (0,0)", first_x, first_y);
        end
        check_frame("frame_after_rst", 16'd5);
    endtask

    initial begin
        test_reset();
        test_frame_thresh20();
        test_frame_thresh30_bubbles();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
